// File: rtl/wdg_multi_pkg.sv
// Shared types and constants for the multi-channel watchdog (wdg_multi).
package wdg_multi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PULSE = 2'd2
  } ch_state_t;

  localparam int DEF_TMO      = 16;
  localparam int DEF_PLS      = 3;
  localparam int TICK_DIV_SIM = 10;
  localparam int TICK_DIV_HW  = 125_000_000;

endpackage

// File: rtl/wdg_multi_ch.sv
// One watchdog channel: IDLE/ARMED/PULSE FSM, timeout and pulse timers, saturating expiry counter.
// The optional kick window is enabled by defining WDG_WINDOW_EN.
module wdg_multi_ch #(
  parameter int TMO_W = 12,
  parameter int PLS_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kick,
  input  logic             now,
  input  logic             tick,
  input  logic             cnt_clr,
  input  logic [TMO_W-1:0] tmo_val,
  input  logic [PLS_W-1:0] pls_wdth,
`ifdef WDG_WINDOW_EN
  input  logic [TMO_W-1:0] win_val,
  output logic             early_kick,
`endif
  output logic             timeout_n,
  output logic [CNT_W-1:0] expire_cnt
);
  import wdg_multi_pkg::*;

  ch_state_t        state, state_nxt;
  logic [TMO_W-1:0] timer, timer_nxt, tmo_load;
  logic [PLS_W-1:0] pls_timer, pls_timer_nxt, pls_load;
  logic [CNT_W-1:0] cnt_nxt;
  logic             timeout_n_nxt;
  logic             expire;
  logic             early;

  // A zero setting still gives a one-tick timeout or pulse.
  assign tmo_load = (tmo_val == '0)  ? TMO_W'(1'b1) : tmo_val;
  assign pls_load = (pls_wdth == '0) ? PLS_W'(1'b1) : pls_wdth;

`ifdef WDG_WINDOW_EN
  assign early = kick && (win_val < tmo_val) && (timer > win_val);
`else
  assign early = 1'b0;
`endif

  // Next-state, timer and output decode for the channel FSM.
  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    pls_timer_nxt = pls_timer;
    timeout_n_nxt = timeout_n;
    expire        = 1'b0;
    case (state)
      IDLE: begin
        timeout_n_nxt = 1'b1;
        if (en) begin
          state_nxt = ARMED;
          timer_nxt = tmo_load;
        end else begin
          state_nxt = IDLE;
        end
      end
      ARMED: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (now || (timer == '0) || early) begin
          state_nxt     = PULSE;
          pls_timer_nxt = pls_load;
          timeout_n_nxt = 1'b0;
          expire        = 1'b1;
        end else if (kick) begin
          timer_nxt = tmo_load;
        end else if (tick) begin
          timer_nxt = timer - TMO_W'(1'b1);
        end else begin
          timer_nxt = timer;
        end
      end
      PULSE: begin
        if (pls_timer == '0) begin
          timeout_n_nxt = 1'b1;
          if (en) begin
            state_nxt = ARMED;
            timer_nxt = tmo_load;
          end else begin
            state_nxt = IDLE;
          end
        end else if (tick) begin
          pls_timer_nxt = pls_timer - PLS_W'(1'b1);
        end else begin
          pls_timer_nxt = pls_timer;
        end
      end
      default: begin
        state_nxt     = IDLE;
        timeout_n_nxt = 1'b1;
      end
    endcase
  end

  // Expiry counter: a clear coinciding with an expiry leaves a count of one.
  always_comb begin
    cnt_nxt = expire_cnt;
    if (cnt_clr) begin
      cnt_nxt = expire ? CNT_W'(1'b1) : '0;
    end else if (expire && (expire_cnt != '1)) begin
      cnt_nxt = expire_cnt + CNT_W'(1'b1);
    end else begin
      cnt_nxt = expire_cnt;
    end
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      timer      <= '0;
      pls_timer  <= '0;
      timeout_n  <= 1'b1;
      expire_cnt <= '0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      pls_timer  <= pls_timer_nxt;
      timeout_n  <= timeout_n_nxt;
      expire_cnt <= cnt_nxt;
    end
  end

`ifdef WDG_WINDOW_EN
  logic early_hit;
  // Only an early kick that actually wins the ARMED priority sets the flag.
  assign early_hit = (state == ARMED) && en && !now && (timer != '0) && early;

  // Sticky early-kick flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      early_kick <= 1'b0;
    end else begin
      early_kick <= (cnt_clr ? 1'b0 : early_kick) | early_hit;
    end
  end
`endif

endmodule

// File: rtl/wdg_multi.sv
// Multi-channel watchdog top: shared tick prescaler plus NUM_CH wdg_multi_ch channels.
// Defining WDG_WINDOW_EN adds the per-channel kick window (win_val, early_kick).
module wdg_multi
  import wdg_multi_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int TMO_W    = 12,
  parameter int PLS_W    = 8,
  parameter int CNT_W    = 4,
  parameter int TICK_DIV = TICK_DIV_HW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       wdg_en,
  input  logic [NUM_CH-1:0]       wdg_kick,
  input  logic [NUM_CH-1:0]       wdg_now,
  input  logic [NUM_CH*TMO_W-1:0] tmo_val,
  input  logic [PLS_W-1:0]        pls_wdth,
  input  logic                    cnt_clr,
`ifdef WDG_WINDOW_EN
  input  logic [NUM_CH*TMO_W-1:0] win_val,
  output logic [NUM_CH-1:0]       early_kick,
`endif
  output logic [NUM_CH-1:0]       wdg_timeout_n,
  output logic                    any_timeout_n,
  output logic [NUM_CH*CNT_W-1:0] expire_cnt,
  output logic                    tick
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;

  // Prescaler: one-cycle tick every TICK_DIV clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre  <= '0;
      tick <= 1'b0;
    end else if (pre == PRE_MAX) begin
      pre  <= '0;
      tick <= 1'b1;
    end else begin
      pre  <= pre + PRE_W'(1'b1);
      tick <= 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    wdg_multi_ch #(
      .TMO_W(TMO_W),
      .PLS_W(PLS_W),
      .CNT_W(CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .en        (wdg_en[i]),
      .kick      (wdg_kick[i]),
      .now       (wdg_now[i]),
      .tick      (tick),
      .cnt_clr   (cnt_clr),
      .tmo_val   (tmo_val[i*TMO_W +: TMO_W]),
      .pls_wdth  (pls_wdth),
`ifdef WDG_WINDOW_EN
      .win_val   (win_val[i*TMO_W +: TMO_W]),
      .early_kick(early_kick[i]),
`endif
      .timeout_n (wdg_timeout_n[i]),
      .expire_cnt(expire_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign any_timeout_n = &wdg_timeout_n;

endmodule

// File: tb/tb_wdg_multi.sv
// Directed self-checking bench for wdg_multi (TICK_DIV=10, NUM_CH=4); window checks need WDG_WINDOW_EN.
module tb_wdg_multi;
  import wdg_multi_pkg::*;

  localparam int NUM_CH = 4;
  localparam int TMO_W  = 12;
  localparam int PLS_W  = 8;
  localparam int CNT_W  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       wdg_en, wdg_kick, wdg_now;
  logic [NUM_CH*TMO_W-1:0] tmo_val;
  logic [PLS_W-1:0]        pls_wdth;
  logic                    cnt_clr;
  logic [NUM_CH-1:0]       wdg_timeout_n;
  logic                    any_timeout_n;
  logic [NUM_CH*CNT_W-1:0] expire_cnt;
  logic                    tick;
`ifdef WDG_WINDOW_EN
  logic [NUM_CH*TMO_W-1:0] win_val;
  logic [NUM_CH-1:0]       early_kick;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wdg_multi #(
    .NUM_CH(NUM_CH), .TMO_W(TMO_W), .PLS_W(PLS_W), .CNT_W(CNT_W), .TICK_DIV(TICK_DIV_SIM)
  ) dut (
    .clk(clk), .rst(rst), .wdg_en(wdg_en), .wdg_kick(wdg_kick), .wdg_now(wdg_now),
    .tmo_val(tmo_val), .pls_wdth(pls_wdth), .cnt_clr(cnt_clr),
`ifdef WDG_WINDOW_EN
    .win_val(win_val), .early_kick(early_kick),
`endif
    .wdg_timeout_n(wdg_timeout_n), .any_timeout_n(any_timeout_n),
    .expire_cnt(expire_cnt), .tick(tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [31:0] cnt_of(input int ch);
    return 32'(expire_cnt[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic set_tmo(input int ch, input int v);
    tmo_val[ch*TMO_W +: TMO_W] = TMO_W'(v);
  endtask

  // Counts negedges until wdg_timeout_n[ch] equals lvl; returns budget on expiry.
  task automatic wait_level(input int ch, input logic lvl, input int budget, output int cyc);
    cyc = 0;
    while (wdg_timeout_n[ch] !== lvl && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_tick();
    int g = 0;
    while (tick !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
  endtask

  // Returns on the negedge right after the n-th observed tick has been consumed.
  task automatic count_ticks(input int n);
    int seen = 0;
    int g = 0;
    while (seen < n && g < 200) begin
      if (tick === 1'b1) seen++;
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int   c;
    logic seen_low;

    rst      = 1'b1;
    wdg_en   = '0;
    wdg_kick = '0;
    wdg_now  = '0;
    cnt_clr  = 1'b0;
    tmo_val  = {NUM_CH{TMO_W'(DEF_TMO)}};
    pls_wdth = PLS_W'(DEF_PLS);
`ifdef WDG_WINDOW_EN
    win_val  = '1;
`endif
    repeat (3) @(negedge clk);
    check("rst_tmo_n", 32'(wdg_timeout_n), 32'hf);
    check("rst_any", 32'(any_timeout_n), 32'h1);
    check("rst_cnt", 32'(expire_cnt), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    rst = 1'b0;

    // 1: free-running expiry on channel 0
    set_tmo(0, 5);
    pls_wdth  = 8'd3;
    wdg_en[0] = 1'b1;
    wait_level(0, 1'b0, 80, c);
    check("t1_latency", 32'(in_rng(c, 40, 60)), 32'h1);
    check("t1_cnt1", cnt_of(0), 32'd1);
    wait_level(0, 1'b1, 80, c);
    check("t1_pulse_len", 32'(in_rng(c, 20, 40)), 32'h1);
    wait_level(0, 1'b0, 80, c);
    check("t1_rearm_latency", 32'(in_rng(c, 40, 60)), 32'h1);
    check("t1_cnt2", cnt_of(0), 32'd2);
    wdg_en[0] = 1'b0;
    wait_level(0, 1'b1, 80, c);

    // 2: regular kicks keep channel 1 alive; kick on a tick reloads
    set_tmo(1, 5);
    wdg_en[1] = 1'b1;
    seen_low  = 1'b0;
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (wdg_timeout_n[1] !== 1'b1) seen_low = 1'b1;
      end
      wdg_kick[1] = 1'b1;
      @(negedge clk);
      wdg_kick[1] = 1'b0;
    end
    check("t2_no_pulse", 32'(seen_low), 32'h0);
    check("t2_cnt", cnt_of(1), 32'd0);
    wait_tick();
    wdg_kick[1] = 1'b1;
    @(negedge clk);
    wdg_kick[1] = 1'b0;
    wait_level(1, 1'b0, 80, c);
    check("t2_kick_on_tick", 32'(c), 32'd51);
    check("t2_cnt_after", cnt_of(1), 32'd1);
    wdg_en[1] = 1'b0;
    wait_level(1, 1'b1, 80, c);

    // 3: forced expiry on channel 2
    set_tmo(2, 20);
    wdg_en[2] = 1'b1;
    repeat (5) @(negedge clk);
    wdg_now[2] = 1'b1;
    @(negedge clk);
    wdg_now[2] = 1'b0;
    check("t3_outputs", 32'(wdg_timeout_n), 32'hb);
    check("t3_any_low", 32'(any_timeout_n), 32'h0);
    check("t3_cnt", cnt_of(2), 32'd1);
    wdg_en[2] = 1'b0;
    wait_level(2, 1'b1, 80, c);
    check("t3_any_high", 32'(any_timeout_n), 32'h1);

    // 4: disable mid-pulse, re-enable, zero timeout and zero pulse width
    set_tmo(3, 5);
    wdg_en[3] = 1'b1;
    wait_level(3, 1'b0, 80, c);
    check("t4_latency", 32'(in_rng(c, 40, 60)), 32'h1);
    @(negedge clk);
    wdg_en[3] = 1'b0;
    wait_level(3, 1'b1, 80, c);
    check("t4_full_pulse", 32'(in_rng(c, 19, 40)), 32'h1);
    seen_low = 1'b0;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (wdg_timeout_n[3] !== 1'b1) seen_low = 1'b1;
    end
    check("t4_idle", 32'(seen_low), 32'h0);
    wdg_en[3] = 1'b1;
    wait_level(3, 1'b0, 80, c);
    check("t4_restart", 32'(in_rng(c, 40, 60)), 32'h1);
    check("t4_cnt", cnt_of(3), 32'd2);
    wdg_en[3] = 1'b0;
    set_tmo(3, 0);
    pls_wdth = 8'd0;
    wait_level(3, 1'b1, 80, c);
    @(negedge clk);
    wdg_en[3] = 1'b1;
    wait_level(3, 1'b0, 30, c);
    check("t4_tmo_zero", 32'(in_rng(c, 2, 14)), 32'h1);
    wait_level(3, 1'b1, 30, c);
    check("t4_pls_zero", 32'(in_rng(c, 1, 13)), 32'h1);
    wdg_en[3] = 1'b0;
    repeat (15) @(negedge clk);
    check("t4_off", 32'(wdg_timeout_n[3]), 32'h1);

    // 5: saturation and clear-with-expiry on channel 0
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("t5_clear", 32'(expire_cnt), 32'h0);
    set_tmo(0, 20);
    wdg_en[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      wdg_now[0] = 1'b1;
      @(negedge clk);
      wdg_now[0] = 1'b0;
      wait_level(0, 1'b1, 40, c);
    end
    check("t5_saturate", cnt_of(0), 32'd15);
    wdg_now[0] = 1'b1;
    cnt_clr    = 1'b1;
    @(negedge clk);
    wdg_now[0] = 1'b0;
    cnt_clr    = 1'b0;
    check("t5_clear_with_expiry", 32'(expire_cnt), 32'h0001);

    // 6: window (optional build) and asynchronous reset mid-pulse
    set_tmo(0, 10);
    pls_wdth = 8'd3;
`ifdef WDG_WINDOW_EN
    win_val[0*TMO_W +: TMO_W] = 12'd4;
`endif
    wait_level(0, 1'b1, 40, c);
`ifdef WDG_WINDOW_EN
    count_ticks(3);
    wdg_kick[0] = 1'b1;
    @(negedge clk);
    wdg_kick[0] = 1'b0;
    check("t6_early_pulse", 32'(wdg_timeout_n[0]), 32'h0);
    check("t6_early_flag", 32'(early_kick), 32'h1);
    check("t6_early_cnt", cnt_of(0), 32'd2);
    wait_level(0, 1'b1, 80, c);
    count_ticks(7);
    wdg_kick[0] = 1'b1;
    @(negedge clk);
    wdg_kick[0] = 1'b0;
    seen_low = 1'b0;
    for (int j = 0; j < 60; j++) begin
      if (wdg_timeout_n[0] !== 1'b1) seen_low = 1'b1;
      @(negedge clk);
    end
    check("t6_late_kick_reload", 32'(seen_low), 32'h0);
    check("t6_late_cnt", cnt_of(0), 32'd2);
`endif
    wdg_now[0] = 1'b1;
    @(negedge clk);
    wdg_now[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_pre_rst_low", 32'(wdg_timeout_n[0]), 32'h0);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_tmo_n", 32'(wdg_timeout_n), 32'hf);
    check("t6_rst_any", 32'(any_timeout_n), 32'h1);
    check("t6_rst_cnt", 32'(expire_cnt), 32'h0);
    check("t6_rst_tick", 32'(tick), 32'h0);
`ifdef WDG_WINDOW_EN
    check("t6_rst_early", 32'(early_kick), 32'h0);
`endif
    @(negedge clk);
    wdg_en = '0;
    rst    = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
